count_sequencer: RTL and testbench

Enable-pulse sequencer that sits directly upstream of the 8-bit counter and drives its `enable` input. It divides `clk` by a programmable prescale value and emits single-cycle enable pulses, either continuously or as a fixed-length burst, under start/stop control. It reports `busy` while running and a one-cycle `done` pulse when a burst completes.

---
 rtl/count_sequencer.sv | 132 +++++++++++++
 tb/tb_count_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// Enable-pulse sequencer for the downstream 8-bit counter: prescaled single-cycle
// enable pulses, continuous or fixed-length burst. Optional run gate: COUNT_SEQ_GATE_EN.
module count_sequencer #(
    parameter int PRESCALE_W = 8,
    parameter int BURST_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BURST_W-1:0]    burst_len,
`ifdef COUNT_SEQ_GATE_EN
    input  logic                  gate,
`endif
    output logic                  enable,
    output logic                  busy,
    output logic                  done
);

    // state  | meaning
    // IDLE   | waiting for start; parameters latched on acceptance
    // RUN    | dividing clk, emitting enable pulses
    // DONE   | single cycle after the last burst pulse; raises done
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state, state_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [BURST_W-1:0]    burst_q, burst_d;
    logic                  mode_q, mode_d;
    logic [PRESCALE_W-1:0] div, div_d;
    logic [BURST_W-1:0]    pulses, pulses_d;
    logic                  enable_d, busy_d, done_d;
    logic                  run_gate;
    logic [BURST_W-1:0]    burst_last;

`ifdef COUNT_SEQ_GATE_EN
    assign run_gate = gate;
`else
    assign run_gate = 1'b1;
`endif

    // burst_q of 0 wraps to all-ones here, giving a 2^BURST_W pulse burst
    assign burst_last = burst_q - BURST_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            prescale_q <= '0;
            burst_q    <= '0;
            mode_q     <= 1'b0;
            div        <= '0;
            pulses     <= '0;
            enable     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            prescale_q <= prescale_d;
            burst_q    <= burst_d;
            mode_q     <= mode_d;
            div        <= div_d;
            pulses     <= pulses_d;
            enable     <= enable_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    always_comb begin
        state_d    = state;
        prescale_d = prescale_q;
        burst_d    = burst_q;
        mode_d     = mode_q;
        div_d      = div;
        pulses_d   = pulses;
        enable_d   = 1'b0;
        busy_d     = busy;
        done_d     = 1'b0;

        case (state)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start && !stop) begin
                    prescale_d = prescale;
                    burst_d    = burst_len;
                    mode_d     = mode;
                    div_d      = '0;
                    pulses_d   = '0;
                    busy_d     = 1'b1;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                busy_d = 1'b1;
                if (stop) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (!run_gate) begin
                    // hold div and pulses so spacing resumes where it paused
                    div_d    = div;
                    pulses_d = pulses;
                end else if (div == prescale_q) begin
                    div_d    = '0;
                    enable_d = 1'b1;
                    if (mode_q && (pulses == burst_last)) begin
                        state_d = S_DONE;
                    end else begin
                        pulses_d = pulses + BURST_W'(1);
                    end
                end else begin
                    div_d = div + PRESCALE_W'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: stimulus queues expected enable/done events,
// a negedge monitor pops and compares them. Gate test built with COUNT_SEQ_GATE_EN.
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, stop, mode;
    logic [7:0] prescale, burst_len;
`ifdef COUNT_SEQ_GATE_EN
    logic       gate;
`endif
    logic       enable, busy, done;

    typedef struct {
        bit is_done;
        int at;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] cnt;

    count_sequencer #(.PRESCALE_W(8), .BURST_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .prescale  (prescale),
        .burst_len (burst_len),
`ifdef COUNT_SEQ_GATE_EN
        .gate      (gate),
`endif
        .enable    (enable),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // downstream counter driven by enable
    always @(posedge clk) begin
        if (reset) cnt <= 8'd0;
        else if (enable) cnt <= cnt + 8'd1;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (enable || done) begin
            if (exp_q.size() == 0) begin
                check(done ? "unexpected_done" : "unexpected_enable", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", int'(done), int'(mon_e.is_done));
                check("event_cycle", cyc, mon_e.at);
                check("event_busy", int'(busy), mon_e.is_done ? 0 : 1);
            end
        end
    end

    // Called at a negedge; the following posedge is the acceptance edge e0.
    task automatic launch(input bit m, input int p, input int len, input bit push,
                          output int e0);
        int n;
        mode      = m;
        prescale  = 8'(p);
        burst_len = 8'(len);
        start     = 1'b1;
        e0        = cyc + 1;
        if (push) begin
            n = (len == 0) ? 256 : len;
            for (int k = 1; k <= n; k++) exp_q.push_back('{1'b0, e0 + k * (p + 1)});
            exp_q.push_back('{1'b1, e0 + n * (p + 1) + 1});
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int         e0, bad;
        logic [7:0] c0;

        reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
        prescale = 8'd0; burst_len = 8'd0;
`ifdef COUNT_SEQ_GATE_EN
        gate = 1'b1;
`endif
        repeat (2) @(negedge clk);
        check("reset_enable", int'(enable), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        reset = 1'b0;

        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (enable || busy || done) bad++;
        end
        check("idle_quiet", bad, 0);

        // burst P=3 len=5 with overlapping start pulses during RUN
        c0 = cnt;
        launch(1'b1, 3, 5, 1'b1, e0);
        check("burst_busy_after_e0", int'(busy), 1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        drain("burst5_drain", 60);
        check("burst5_count", int'(8'(cnt - c0)), 5);
        check("burst5_busy_low", int'(busy), 0);

        // new start accepted in the done cycle
        c0 = cnt;
        launch(1'b1, 1, 2, 1'b1, e0);
        repeat (5) @(negedge clk);
        check("done_cycle", int'(done), 1);
        launch(1'b1, 0, 3, 1'b1, e0);
        drain("back_to_back_drain", 40);
        check("back_to_back_count", int'(8'(cnt - c0)), 5);

        // continuous P=0, stop sampled at e0+11
        c0 = cnt;
        launch(1'b0, 0, 0, 1'b0, e0);
        for (int k = 1; k <= 10; k++) exp_q.push_back('{1'b0, e0 + k});
        repeat (10) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_enable_low", int'(enable), 0);
        check("stop_busy_low", int'(busy), 0);
        repeat (5) @(negedge clk);
        drain("cont_drain", 5);
        check("cont_count", int'(8'(cnt - c0)), 10);

        // continuous P=255: div spans its full range
        launch(1'b0, 255, 0, 1'b0, e0);
        exp_q.push_back('{1'b0, e0 + 256});
        exp_q.push_back('{1'b0, e0 + 512});
        repeat (512) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("p255_busy_low", int'(busy), 0);
        drain("p255_drain", 5);

        // burst_len=0 means 256 pulses; counter wraps back
        c0 = cnt;
        launch(1'b1, 0, 0, 1'b1, e0);
        drain("burst256_drain", 400);
        check("burst256_count_wrap", int'(8'(cnt - c0)), 0);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1; mode = 1'b1; prescale = 8'd0; burst_len = 8'd1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        bad = 0;
        repeat (5) begin
            if (busy || enable || done) bad++;
            @(negedge clk);
        end
        check("start_stop_idle", bad, 0);

        // reset after 2 of 5 pulses, then a full fresh burst
        launch(1'b1, 3, 5, 1'b0, e0);
        exp_q.push_back('{1'b0, e0 + 4});
        exp_q.push_back('{1'b0, e0 + 8});
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_enable", int'(enable), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_done", int'(done), 0);
        drain("midreset_partial", 2);
        c0 = cnt;
        launch(1'b1, 3, 5, 1'b1, e0);
        drain("midreset_fresh_drain", 60);
        check("midreset_fresh_count", int'(8'(cnt - c0)), 5);

`ifdef COUNT_SEQ_GATE_EN
        // P=1 burst 4, gate low for 6 edges after the first pulse
        c0 = cnt;
        launch(1'b1, 1, 4, 1'b0, e0);
        exp_q.push_back('{1'b0, e0 + 2});
        exp_q.push_back('{1'b0, e0 + 10});
        exp_q.push_back('{1'b0, e0 + 12});
        exp_q.push_back('{1'b0, e0 + 14});
        exp_q.push_back('{1'b1, e0 + 15});
        repeat (2) @(negedge clk);
        gate = 1'b0;
        repeat (3) @(negedge clk);
        check("gate_busy_held", int'(busy), 1);
        repeat (3) @(negedge clk);
        gate = 1'b1;
        drain("gate_drain", 30);
        check("gate_count", int'(8'(cnt - c0)), 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
